// File: rtl/cfg_pkg.sv
// Shared types and default constants for the tile configuration bitstream loader.
package cfg_pkg;

  localparam int         DEFAULT_FRAME_W    = 33;
  localparam int         DEFAULT_NUM_FRAMES = 6;
  localparam logic [7:0] DEFAULT_SYNC_WORD  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic int bytes_per_frame(input int frame_w);
    return (frame_w + 7) / 8;
  endfunction

endpackage

// File: rtl/cfg_bitstream_loader_if.sv
// Byte-serial config input plus frame write port toward the tile array.
interface cfg_bitstream_loader_if #(
  parameter int FRAME_W = cfg_pkg::DEFAULT_FRAME_W,
  parameter int ADDR_W  = $clog2(cfg_pkg::DEFAULT_NUM_FRAMES)
);
  logic [7:0]         cfg_data;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FRAME_W-1:0] frame_data;
  logic [ADDR_W-1:0]  frame_addr;
  logic               frame_we;
  logic               cfg_done;
  logic               cfg_error;

  modport master (
    output cfg_data, cfg_valid,
    input  cfg_ready, frame_data, frame_addr, frame_we, cfg_done, cfg_error
  );

  modport slave (
    input  cfg_data, cfg_valid,
    output cfg_ready, frame_data, frame_addr, frame_we, cfg_done, cfg_error
  );
endinterface

// File: rtl/cfg_frame_assembler.sv
// Collects LSB-first bytes into a frame; the finished frame is registered and
// announced by a one-cycle frame_complete pulse the cycle after its last byte.
module cfg_frame_assembler
  import cfg_pkg::*;
#(
  parameter int FRAME_W = DEFAULT_FRAME_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               byte_vld_i,
  input  logic [7:0]         byte_dat_i,
  output logic               byte_last_o,
  output logic [FRAME_W-1:0] frame_dat_o,
  output logic               frame_complete_o
);
  localparam int BYTES = bytes_per_frame(FRAME_W);
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0]   cnt_q;
  logic [BYTES*8-1:0] asm_q, asm_d;
  logic [FRAME_W-1:0] frame_q;
  logic               complete_q;

  assign byte_last_o = (cnt_q == CNT_W'(BYTES - 1));

  always_comb begin
    asm_d = asm_q;
    asm_d[{cnt_q, 3'b000} +: 8] = byte_dat_i;
  end

  // Top bits of the last byte beyond FRAME_W are dropped when the frame is latched.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      asm_q      <= '0;
      frame_q    <= '0;
      complete_q <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      if (clr_i) begin
        cnt_q <= '0;
      end else if (byte_vld_i) begin
        asm_q <= asm_d;
        if (byte_last_o) begin
          cnt_q      <= '0;
          frame_q    <= asm_d[FRAME_W-1:0];
          complete_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign frame_dat_o      = frame_q;
  assign frame_complete_o = complete_q;
endmodule

// File: rtl/cfg_bitstream_loader.sv
// Bitstream loader: sync/header check, frame writes by index, sticky done/error.
// CFG_LOADER_CHECKSUM_EN adds an XOR trailer byte check after the last frame.
module cfg_bitstream_loader
  import cfg_pkg::*;
#(
  parameter int         FRAME_W    = DEFAULT_FRAME_W,
  parameter int         NUM_FRAMES = DEFAULT_NUM_FRAMES,
  parameter logic [7:0] SYNC_WORD  = DEFAULT_SYNC_WORD
) (
  input logic                   clock,
  input logic                   reset,
  cfg_bitstream_loader_if.slave bus
);
  localparam int                ADDR_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [7:0]        NUM_FRAMES_B = 8'(NUM_FRAMES);
  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_FRAMES - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ready_q;
  logic               xfer, load_byte, byte_last, frame_last, asm_clr;
  logic               frame_complete;
  logic [FRAME_W-1:0] frame_dat;

  assign xfer       = bus.cfg_valid & ready_q;
  assign load_byte  = xfer && (state_q == ST_LOAD);
  assign frame_last = load_byte && byte_last;

  cfg_frame_assembler #(.FRAME_W(FRAME_W)) u_asm (
    .clock            (clock),
    .reset            (reset),
    .clr_i            (asm_clr),
    .byte_vld_i       (load_byte),
    .byte_dat_i       (bus.cfg_data),
    .byte_last_o      (byte_last),
    .frame_dat_o      (frame_dat),
    .frame_complete_o (frame_complete)
  );

`ifdef CFG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (asm_clr)        csum_d = '0;
    else if (load_byte) csum_d = csum_q ^ bus.cfg_data;
  end

  always_ff @(posedge clock) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    asm_clr = 1'b0;
    case (state_q)
      ST_IDLE: if (xfer && bus.cfg_data == SYNC_WORD) state_d = ST_HEADER;
      ST_HEADER: begin
        if (xfer) begin
          if (bus.cfg_data == NUM_FRAMES_B) begin
            state_d = ST_LOAD;
            idx_d   = '0;
            asm_clr = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_LOAD: begin
        // Address is latched with the frame so it stays paired with frame_data until the next strobe.
        if (frame_last) begin
          addr_d = idx_q;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
`ifdef CFG_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef CFG_LOADER_CHECKSUM_EN
      ST_CHECK: if (xfer) state_d = (bus.cfg_data == csum_q) ? ST_DONE : ST_ERROR;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      ready_q <= (state_d == ST_IDLE) || (state_d == ST_HEADER) ||
                 (state_d == ST_LOAD) || (state_d == ST_CHECK);
    end
  end

  assign bus.cfg_ready  = ready_q;
  assign bus.frame_data = frame_dat;
  assign bus.frame_addr = addr_q;
  assign bus.frame_we   = frame_complete;
  assign bus.cfg_done   = (state_q == ST_DONE);
  assign bus.cfg_error  = (state_q == ST_ERROR);
endmodule
